alu_md_unit: RTL and testbench

Parametrised execute-stage unit for the 5-stage pipeline that succeeds the single-cycle ALU. It keeps the forwarding operand selection and the SUB/zero branch-compare path. It adds compare and shift ops plus iterative unsigned multiply/divide with a valid/ready handshake and a busy output that stalls the front of the pipeline. All results are registered.

---
 rtl/riscv_pkg.sv | 41 ++++
 rtl/alu_md_iter.sv | 69 ++++++
 rtl/alu_md_unit.sv | 149 ++++++++++++++
 tb/tb_alu_md_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the execute stage: ALU/MD opcodes, MD sequencer states
// and forwarding-select codes.
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_MUL   = 4'd10,
        ALU_MULHU = 4'd11,
        ALU_DIVU  = 4'd12,
        ALU_REMU  = 4'd13
    } alu_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_ITER = 2'd1,
        MD_FIN  = 2'd2
    } md_state_t;

    localparam logic [1:0] FWD_RD  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;
    localparam logic [1:0] FWD_ALT = 2'b11;

    function automatic logic is_md_op(input alu_op_t op);
        return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

    function automatic logic is_div_op(input alu_op_t op);
        return (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Multiply leaves {hi,lo} = a*b; divide leaves lo = quotient, hi = remainder.
module alu_md_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            start,
    input  logic            div_mode,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    logic [XLEN-1:0]  hi_reg, lo_reg, b_reg;
    logic [XLEN-1:0]  hi_next, lo_next;
    logic             div_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [XLEN:0]    mul_sum, shifted, diff;

    always_comb begin
        mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : {(XLEN+1){1'b0}});
        shifted = {hi_reg, lo_reg[XLEN-1]};
        diff    = shifted - {1'b0, b_reg};
        hi_next = mul_sum[XLEN:1];
        lo_next = {mul_sum[0], lo_reg[XLEN-1:1]};
        if (div_reg) begin
            // Borrow out of the trial subtraction means restore (quotient bit 0).
            if (!diff[XLEN]) begin
                hi_next = diff[XLEN-1:0];
                lo_next = {lo_reg[XLEN-2:0], 1'b1};
            end else begin
                hi_next = shifted[XLEN-1:0];
                lo_next = {lo_reg[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_reg  <= '0;
            lo_reg  <= '0;
            b_reg   <= '0;
            div_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (flush) begin
            cnt_reg <= '0;
        end else if (start) begin
            hi_reg  <= '0;
            lo_reg  <= a;
            b_reg   <= b;
            div_reg <= div_mode;
            cnt_reg <= CNT_W'(XLEN);
        end else if (cnt_reg != '0) begin
            hi_reg  <= hi_next;
            lo_reg  <= lo_next;
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign done = (cnt_reg == CNT_W'(1));
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: rtl/alu_md_unit.sv
// Execute-stage unit: forwarding muxes, single-cycle ALU with SUB/zero compare,
// and a sequencer around the iterative multiply/divide datapath.
module alu_md_unit
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  alu_op_t         op,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] fwd_mem,
    input  logic [XLEN-1:0] fwd_wb,
    input  logic [1:0]      sel_a,
    input  logic [1:0]      sel_b,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);

    md_state_t       state_reg, state_next;
    alu_op_t         op_reg;
    logic [XLEN-1:0] result_reg, result_next, single_result;
    logic [XLEN-1:0] a, b, iter_hi, iter_lo;
    logic            zero_reg, zero_next, out_valid_reg, out_valid_next;
    logic            load_result, iter_start, iter_done, accept;
    logic [SHW-1:0]  shamt;

    always_comb begin
        case (sel_a)
            FWD_MEM: a = fwd_mem;
            FWD_WB:  a = fwd_wb;
            default: a = rd1;
        endcase
        case (sel_b)
            FWD_MEM: b = fwd_mem;
            FWD_WB:  b = fwd_wb;
            FWD_ALT: b = imm;
            default: b = rd2;
        endcase
    end

    assign shamt = b[SHW-1:0];

    // Divide-by-zero results are produced here so they share the 1-cycle path.
    always_comb begin
        case (op)
            ALU_ADD:  single_result = a + b;
            ALU_SUB:  single_result = a - b;
            ALU_AND:  single_result = a & b;
            ALU_OR:   single_result = a | b;
            ALU_XOR:  single_result = a ^ b;
            ALU_SLT:  single_result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: single_result = {{(XLEN-1){1'b0}}, a < b};
            ALU_SLL:  single_result = a << shamt;
            ALU_SRL:  single_result = a >> shamt;
            ALU_SRA:  single_result = $unsigned($signed(a) >>> shamt);
            ALU_DIVU: single_result = '1;
            ALU_REMU: single_result = a;
            default:  single_result = '0;
        endcase
    end

    assign busy     = (state_reg != MD_IDLE);
    assign in_ready = !busy;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next     = state_reg;
        out_valid_next = 1'b0;
        load_result    = 1'b0;
        result_next    = result_reg;
        zero_next      = 1'b0;
        iter_start     = 1'b0;
        case (state_reg)
            MD_IDLE: begin
                if (accept && !flush) begin
                    if (is_md_op(op) && !(is_div_op(op) && (b == '0))) begin
                        iter_start = 1'b1;
                        state_next = MD_ITER;
                    end else begin
                        load_result    = 1'b1;
                        out_valid_next = 1'b1;
                        result_next    = single_result;
                        zero_next      = (op == ALU_SUB) && (a == b);
                    end
                end
            end
            MD_ITER: begin
                if (flush)          state_next = MD_IDLE;
                else if (iter_done) state_next = MD_FIN;
            end
            MD_FIN: begin
                state_next = MD_IDLE;
                if (!flush) begin
                    load_result    = 1'b1;
                    out_valid_next = 1'b1;
                    result_next    = (op_reg == ALU_MUL || op_reg == ALU_DIVU) ? iter_lo : iter_hi;
                end
            end
            default: state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= MD_IDLE;
            op_reg        <= ALU_ADD;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            if (iter_start) op_reg <= op;
            if (load_result) begin
                result_reg <= result_next;
                zero_reg   <= zero_next;
            end
        end
    end

    alu_md_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .start    (iter_start),
        .div_mode (is_div_op(op)),
        .a        (a),
        .b        (b),
        .done     (iter_done),
        .hi       (iter_hi),
        .lo       (iter_lo)
    );

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_alu_md_unit.sv
// Directed-vector bench for alu_md_unit (XLEN=32) with hand-computed expectations.
module tb_alu_md_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    alu_op_t     op;
    logic [31:0] rd1, rd2, imm, fwd_mem, fwd_wb, result;
    logic [1:0]  sel_a, sel_b;
    logic        out_valid, zero, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_md_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rd1       (rd1),
        .rd2       (rd2),
        .imm       (imm),
        .fwd_mem   (fwd_mem),
        .fwd_wb    (fwd_wb),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic drive(input alu_op_t o, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
        op = o; sel_a = sa; sel_b = sb; rd1 = r1; rd2 = r2; imm = im;
        in_valid = 1'b1;
    endtask

    task automatic single(input string tag, input alu_op_t o, input logic [1:0] sa,
                          input logic [1:0] sb, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] im, input logic [31:0] exp_res, input logic exp_zero);
        drive(o, sa, sb, r1, r2, im);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".result"}, result, exp_res);
        check({tag, ".zero"}, 32'(zero), 32'(exp_zero));
    endtask

    // Runs an op through rd1/rd2, measures cycles from acceptance to out_valid.
    task automatic run_md(input string tag, input alu_op_t o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_res,
                          input int exp_lat, input int exp_busy);
        int lat;
        int busy_cycles;
        drive(o, FWD_RD, FWD_RD, x, y, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        busy_cycles = 0;
        while (!out_valid && lat < 100) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".busy_cycles"}, 32'(busy_cycles), 32'(exp_busy));
        check({tag, ".result"}, result, exp_res);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check({tag, ".single_pulse"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int pulses;
        logic [31:0] held;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; op = ALU_ADD;
        rd1 = '0; rd2 = '0; imm = '0; fwd_mem = '0; fwd_wb = '0; sel_a = '0; sel_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.result", result, 32'd0);
        check("rst.zero", 32'(zero), 32'd0);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        single("add_imm", ALU_ADD, FWD_RD, FWD_ALT, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd4, 1'b0);
        @(posedge clk); #1;
        check("add_imm.no_repeat", 32'(out_valid), 32'd0);

        // SUB then SLT back-to-back
        drive(ALU_SUB, FWD_RD, FWD_RD, 32'h1234, 32'h1234, 32'd0);
        @(posedge clk); #1;
        check("sub_eq.valid", 32'(out_valid), 32'd1);
        check("sub_eq.result", result, 32'd0);
        check("sub_eq.zero", 32'(zero), 32'd1);
        drive(ALU_SLT, FWD_RD, FWD_RD, 32'hFFFF_FFFF, 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("slt_neg.valid", 32'(out_valid), 32'd1);
        check("slt_neg.result", result, 32'd1);
        check("slt_neg.zero", 32'(zero), 32'd0);

        single("add_equal", ALU_ADD, FWD_RD, FWD_RD, 32'd7, 32'd7, 32'd0, 32'd14, 1'b0);
        single("and", ALU_AND, FWD_RD, FWD_RD, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'h00F0_1200, 1'b0);
        single("or", ALU_OR, FWD_RD, FWD_RD, 32'hF000_0001, 32'h000F_0010, 32'd0, 32'hF00F_0011, 1'b0);
        single("xor", ALU_XOR, FWD_RD, FWD_RD, 32'hFFFF_0000, 32'hF0F0_F0F0, 32'd0, 32'h0F0F_F0F0, 1'b0);
        single("sltu", ALU_SLTU, FWD_RD, FWD_RD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0);
        single("sll_mask", ALU_SLL, FWD_RD, FWD_RD, 32'h8000_0003, 32'h21, 32'd0, 32'h0000_0006, 1'b0);
        single("srl", ALU_SRL, FWD_RD, FWD_RD, 32'h8000_0000, 32'd4, 32'd0, 32'h0800_0000, 1'b0);
        single("sra", ALU_SRA, FWD_RD, FWD_RD, 32'h8000_0000, 32'd4, 32'd0, 32'hF800_0000, 1'b0);
        single("sub_wrap", ALU_SUB, FWD_RD, FWD_RD, 32'd1, 32'd2, 32'd0, 32'hFFFF_FFFF, 1'b0);
        single("undef_op", alu_op_t'(4'hE), FWD_RD, FWD_RD, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0);

        fwd_mem = 32'd10; fwd_wb = 32'd3;
        single("fwd_sub", ALU_SUB, FWD_MEM, FWD_WB, 32'd99, 32'd50, 32'd0, 32'd7, 1'b0);
        single("fwd_add", ALU_ADD, FWD_WB, FWD_MEM, 32'd99, 32'd50, 32'd0, 32'd13, 1'b0);
        single("fwd_a11", ALU_SUB, FWD_ALT, FWD_WB, 32'd20, 32'd50, 32'd0, 32'd17, 1'b0);

        run_md("mul", ALU_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 34, 33);
        run_md("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1, 34, 33);
        run_md("mulhu_big", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 33);
        run_md("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 34, 33);
        run_md("remu", ALU_REMU, 32'd100, 32'd7, 32'd2, 34, 33);
        run_md("divu_top", ALU_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 34, 33);
        run_md("divu_by0", ALU_DIVU, 32'd123, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_md("remu_by0", ALU_REMU, 32'd9, 32'd0, 32'd9, 1, 0);

        // Flush a DIVU at its 10th iteration while an ADD is offered
        held = result;
        drive(ALU_DIVU, FWD_RD, FWD_RD, 32'd100, 32'd7, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("flush.busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        drive(ALU_ADD, FWD_RD, FWD_RD, 32'd1, 32'd1, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush.busy", 32'(busy), 32'd0);
        check("flush.in_ready", 32'(in_ready), 32'd1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) pulses++;
            @(posedge clk); #1;
        end
        check("flush.no_valid", 32'(pulses), 32'd0);
        check("flush.result_held", result, held);

        // Reset in the middle of a MUL
        drive(ALU_MUL, FWD_RD, FWD_RD, 32'hFFFF_FFFF, 32'd2, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst.result", result, 32'd0);
        check("midrst.zero", 32'(zero), 32'd0);
        check("midrst.valid", 32'(out_valid), 32'd0);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid || busy) pulses++;
            @(posedge clk); #1;
        end
        check("midrst.quiet", 32'(pulses), 32'd0);

        single("post_rst_add", ALU_ADD, FWD_RD, FWD_RD, 32'd2, 32'd3, 32'd0, 32'd5, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
